fifo_stream_drainer: RTL and testbench
======================================

// Module: fifo_stream_drainer
// PURPOSE
//  Read-side consumer of the synchronous FIFO. Drives the FIFO's rd_en/empty
//  interface, absorbs its 1-cycle registered read latency in a 3-entry skid
//  buffer, and presents the data as a valid/ready stream with burst framing
//  (m_last every BURST_LEN beats). Sustains 1 beat/clk with m_ready held high.
// PARAMETERS
//  DATA_WIDTH  8   width of FIFO data and stream data
//  BURST_LEN   4   beats per burst; m_last on beat BURST_LEN-1 (>=1)
//  CNT_WIDTH   16  width of total accepted-beat counter
// PORTS
//  clk         in   1           single clock, rising edge
//  rst         in   1           synchronous, active-high reset
//  enable      in   1           1 = issue new FIFO reads; 0 = stop issuing
//  fifo_empty  in   1           FIFO empty flag
//  fifo_data   in   DATA_WIDTH  FIFO data_out (valid 1 clk after rd_en&!empty)
//  fifo_rd_en  out  1           FIFO read request
//  m_valid     out  1           stream data valid
//  m_ready     in   1           stream sink ready
//  m_data      out  DATA_WIDTH  stream data
//  m_last      out  1           last beat of current burst
//  beat_cnt    out  CNT_WIDTH   total beats accepted (m_valid&m_ready), wraps
// BEHAVIOUR
//  Reset (rst=1 at edge): occ=0, inflight=0, burst_idx=0, beat_cnt=0, buffer
//   data=0. During rst: fifo_rd_en=0, m_valid=0, m_data=0, m_last=0.
//  Read issue: fifo_rd_en = !rst & enable & !fifo_empty & (occ+inflight < 3).
//   Never asserted while fifo_empty=1 (every rd_en is a real FIFO read).
//   No combinational path from m_ready to fifo_rd_en.
//  inflight <= fifo_rd_en (registered). When inflight=1, fifo_data is
//   written into buffer tail at that edge. Latency: rd_en in cycle N ->
//   captured end of N+1 -> m_valid earliest in cycle N+2.
//  Buffer: 3-entry circular (2-bit rd/wr ptrs, occ 0..3). Push=inflight,
//   pop=m_valid&m_ready; simultaneous push+pop keeps occ, both ptrs advance.
//   Credit rule guarantees no push when occ=3 (overflow is a design error;
//   bench asserts it never occurs).
//  Stream: m_valid = (occ!=0); m_data = head entry. While m_valid&!m_ready,
//   m_data and m_last hold stable. m_valid never drops without a pop.
//  Framing: burst_idx counts pops, 0..BURST_LEN-1, wraps to 0 on pop at
//   BURST_LEN-1. m_last = m_valid & (burst_idx==BURST_LEN-1). BURST_LEN=1 ->
//   m_last=m_valid. beat_cnt += 1 on every pop, wraps at 2^CNT_WIDTH.
//  enable=0: new reads stop next cycle; in-flight word still captured;
//   buffer continues to drain. burst_idx is NOT reset by enable.
//  Reset mid-burst: in-flight and buffered words discarded, burst_idx=0.
//   FIFO must be reset in the same cycle (system ties rst_n = ~rst).
// STRUCTURE
//  Shared package fifo_pkg: SKID_DEPTH=3, SKID_PTR_W=2 constants, shared
//  with FIFO-side benches. One sub-module: stream_skid_buf (3-entry buffer,
//  push/pop/occ/head); top holds credit logic, inflight, framing, counter.
// TESTING (DATA_WIDTH=8, BURST_LEN=4)
//  1 Reset: rst=1 3 clks, FIFO holds data -> rd_en=0, m_valid=0, beat_cnt=0.
//  2 Stream: FIFO preloaded 0x01..0x08, m_ready=1 -> m_data 0x01..0x08 on 8
//    consecutive clks, m_last on 0x04 and 0x08, beat_cnt=8, first rd_en to
//    first m_valid = 2 clks.
//  3 Backpressure: m_ready=0 for 10 clks -> exactly 3 rd_en pulses, occ=3,
//    m_data stable at head; release -> in-order, no loss, no duplicate.
//  4 Empty gap: FIFO empties after 0x05, refill 0x06 5 clks later ->
//    rd_en never with empty=1, m_last on 0x04 and 0x08 (framing spans gap).
//  5 enable=0 while rd_en high -> that word still delivered, no further
//    rd_en; enable=1 resumes sequence without skip.
//  6 rst during burst (after 0x02 accepted, 2 buffered) -> outputs 0 next
//    clk; after refill 0xA0.. , m_last on 4th beat after reset.
//  Random m_ready/enable/fill with scoreboard vs FIFO write order.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side consumers.
// Holds the skid-buffer geometry and a small helper for pointer wrap.
package fifo_pkg;

    // Entries in the read-side skid buffer. Three entries cover one word in
    // flight from the FIFO plus one word per cycle of sink round trip.
    localparam int SKID_DEPTH = 3;
    localparam int SKID_PTR_W = 2;

    typedef logic [SKID_PTR_W-1:0] skid_ptr_t;
    typedef logic [SKID_PTR_W-1:0] skid_occ_t;  // 0..SKID_DEPTH fits in the pointer width

    // Advance a circular pointer over 0..SKID_DEPTH-1. Not a power of two,
    // so the wrap is explicit.
    function automatic skid_ptr_t skid_ptr_inc(input skid_ptr_t p);
        return (p == skid_ptr_t'(SKID_DEPTH - 1)) ? '0 : p + skid_ptr_t'(1);
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// 3-entry circular skid buffer between the FIFO read port and the stream.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   push        write push_data at the tail this edge
//   push_data   word to store
//   pop         retire the head entry this edge
//   occ         number of stored entries (0..3)
//   head        oldest stored entry (meaningful when occ != 0)
// The caller guarantees no push when full and no pop when empty.
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output skid_occ_t             occ,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
    skid_ptr_t             rd_ptr_q, rd_ptr_d;
    skid_ptr_t             wr_ptr_q, wr_ptr_d;
    skid_occ_t             occ_q, occ_d;

    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;

        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = skid_ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = skid_ptr_inc(rd_ptr_q);
        end

        // Simultaneous push and pop leaves the count unchanged.
        if (push && !pop) begin
            occ_d = occ_q + skid_occ_t'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - skid_occ_t'(1);
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage array is cleared too, because buffered data is
            // defined as zero after reset; a plain data RAM would skip this.
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_stream_drainer.sv
// Read-side consumer of the synchronous FIFO. Issues FIFO reads against a
// credit budget, absorbs the FIFO's one-cycle registered read latency in a
// 3-entry skid buffer, and presents the words as a valid/ready stream with
// m_last every BURST_LEN beats. Sustains one beat per clock with m_ready high.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   enable       1 = keep issuing FIFO reads
//   fifo_empty   FIFO empty flag
//   fifo_data    FIFO data_out, valid one clock after an accepted read
//   fifo_rd_en   FIFO read request (only when the FIFO is non-empty)
//   m_valid      stream beat available
//   m_ready      stream sink accepts the beat
//   m_data       stream data (head of the skid buffer)
//   m_last       final beat of the current burst
//   beat_cnt     total accepted beats, wrapping
module fifo_stream_drainer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  beat_cnt
);

    // A 1-bit index is kept even for BURST_LEN=1 so the counter has a width.
    localparam int                IDX_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BURST_LEN - 1);

    logic                  inflight_q, inflight_d;
    logic [IDX_W-1:0]      burst_idx_q, burst_idx_d;
    logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;

    skid_occ_t             occ;
    logic [DATA_WIDTH-1:0] head;
    logic                  pop;
    logic [2:0]            credit_used;

    always_comb begin
        // Every issued read owns a buffer slot from issue until it is popped,
        // so occupancy plus the word in flight can never exceed the depth.
        // m_ready is deliberately kept out of this path.
        credit_used = {1'b0, occ} + {2'b00, inflight_q};
        fifo_rd_en  = !rst && enable && !fifo_empty && (credit_used < 3'(SKID_DEPTH));
        inflight_d  = fifo_rd_en;

        m_valid = !rst && (occ != '0);
        m_data  = rst ? '0 : head;
        m_last  = m_valid && (burst_idx_q == LAST_IDX);
        pop     = m_valid && m_ready;

        burst_idx_d = burst_idx_q;
        beat_cnt_d  = beat_cnt_q;
        if (pop) begin
            burst_idx_d = (burst_idx_q == LAST_IDX) ? '0 : burst_idx_q + IDX_W'(1);
            beat_cnt_d  = beat_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q  <= 1'b0;
            burst_idx_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            inflight_q  <= inflight_d;
            burst_idx_q <= burst_idx_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    // The word requested last cycle is on fifo_data now; capture it at the tail.
    stream_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_q),
        .push_data(fifo_data),
        .pop      (pop),
        .occ      (occ),
        .head     (head)
    );

    assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_fifo_stream_drainer.sv
// Bench for fifo_stream_drainer (DATA_WIDTH=8, BURST_LEN=4, CNT_WIDTH=16).
// A queue models the FIFO; a second queue holds every word written to it in
// order and is consumed as beats are accepted on the stream.
module tb_fifo_stream_drainer;

    localparam int DW = 8;
    localparam int BL = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [CW-1:0] beat_cnt;

    fifo_stream_drainer #(.DATA_WIDTH(DW), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];

    int model_idx   = 0;
    int model_beats = 0;
    int outstanding = 0;
    int cycle       = 0;

    logic [DW-1:0] log_data[$];
    logic          log_last[$];
    int            log_cyc[$];
    int            rd_en_seen = 0;
    int            first_rd_cyc = -1;
    int            first_valid_cyc = -1;
    int            pushed = 0;

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    // FIFO model: registered read, junk on the data bus when not reading.
    always @(posedge clk) begin
        if (fifo_rd_en && fifo_q.size() != 0) begin
            fifo_data  <= fifo_q.pop_front();
            fifo_empty <= (fifo_q.size() == 0);
        end else begin
            fifo_data <= DW'($urandom);
        end
    end

    // Monitor on the falling edge: stream ordering, framing, counter, credits.
    always @(negedge clk) begin
        cycle = cycle + 1;
        if (rst) begin
            checks++;
            if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0) begin
                errors++;
                $display("FAIL in_reset_outputs: rd_en=%b valid=%b data=%h last=%b, required all zero",
                         fifo_rd_en, m_valid, m_data, m_last);
            end
            prev_stall = 1'b0;
        end else begin
            checks++;
            if (fifo_rd_en && fifo_empty) begin
                errors++;
                $display("FAIL rd_en_while_empty: cycle %0d rd_en=1 with fifo_empty=1", cycle);
            end
            checks++;
            if (beat_cnt !== CW'(model_beats)) begin
                errors++;
                $display("FAIL beat_cnt: got %0d expected %0d", beat_cnt, CW'(model_beats));
            end
            checks++;
            if (m_last !== (m_valid && model_idx == BL - 1)) begin
                errors++;
                $display("FAIL m_last: got %b expected %b (valid=%b beat in burst %0d)",
                         m_last, (m_valid && model_idx == BL - 1), m_valid, model_idx);
            end
            checks++;
            if (m_valid && outstanding == 0) begin
                errors++;
                $display("FAIL valid_without_read: m_valid=1 with no outstanding read, data=%h", m_data);
            end
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%h last=%b, required 1 %h %b",
                             m_valid, m_data, m_last, prev_data, prev_last);
                end
            end

            if (fifo_rd_en) begin
                rd_en_seen++;
                outstanding++;
                if (first_rd_cyc < 0) first_rd_cyc = cycle;
            end
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cycle;

            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got %h with nothing outstanding", m_data);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        errors++;
                        $display("FAIL stream_order: got %h expected %h", m_data, e);
                    end
                end
                log_data.push_back(m_data);
                log_last.push_back(m_last);
                log_cyc.push_back(cycle);
                model_beats++;
                model_idx = (model_idx + 1) % BL;
                outstanding--;
            end

            checks++;
            if (outstanding > 3) begin
                errors++;
                $display("FAIL skid_overflow: %0d words held or in flight, limit 3", outstanding);
            end

            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
        pushed++;
    endtask

    task automatic clear_log();
        log_data.delete();
        log_last.delete();
        log_cyc.delete();
        rd_en_seen      = 0;
        first_rd_cyc    = -1;
        first_valid_cyc = -1;
        pushed          = 0;
    endtask

    // The FIFO is reset alongside the drainer, so its contents go too.
    task automatic release_reset();
        fifo_q.delete();
        exp_q.delete();
        fifo_empty  = 1'b1;
        model_idx   = 0;
        model_beats = 0;
        outstanding = 0;
        rst         = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d words still pending after %0d clks", name, exp_q.size(), budget);
        end
    endtask

    task automatic check_log(input string name, input logic [DW-1:0] base, input int n, input int last_phase);
        checks++;
        if (log_data.size() != n) begin
            errors++;
            $display("FAIL %s_count: got %0d beats expected %0d", name, log_data.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (log_data[i] !== base + DW'(i) || log_last[i] !== ((i + last_phase) % BL == BL - 1)) begin
                    errors++;
                    $display("FAIL %s_beat%0d: got data=%h last=%b expected data=%h last=%b", name, i,
                             log_data[i], log_last[i], base + DW'(i), ((i + last_phase) % BL == BL - 1));
                end
            end
        end
    endtask

    task automatic test_reset();
        enable  = 1'b1;
        m_ready = 1'b1;
        rst     = 1'b1;
        clear_log();
        for (int i = 0; i < 3; i++) push_word(DW'(8'hE0 + i));
        tick(3);
        checks++;
        if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || beat_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: rd_en=%b valid=%b beat_cnt=%0d, required 0 0 0",
                     fifo_rd_en, m_valid, beat_cnt);
        end
        release_reset();
        tick(2);
        checks++;
        if (m_valid !== 1'b0 || rd_en_seen != 0) begin
            errors++;
            $display("FAIL post_reset_idle: valid=%b reads=%0d, required 0 0", m_valid, rd_en_seen);
        end
    endtask

    task automatic test_stream();
        clear_log();
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push_word(DW'(i));
        wait_drain(40, "stream");
        tick(2);
        check_log("stream", 8'h01, 8, 0);
        for (int i = 1; i < log_cyc.size(); i++) begin
            checks++;
            if (log_cyc[i] != log_cyc[0] + i) begin
                errors++;
                $display("FAIL stream_rate: beat %0d at cycle %0d expected %0d", i, log_cyc[i], log_cyc[0] + i);
            end
        end
        checks++;
        if (beat_cnt !== CW'(8)) begin
            errors++;
            $display("FAIL stream_beat_cnt: got %0d expected 8", beat_cnt);
        end
        checks++;
        if (first_valid_cyc - first_rd_cyc != 2) begin
            errors++;
            $display("FAIL stream_latency: got %0d clks expected 2", first_valid_cyc - first_rd_cyc);
        end
    endtask

    task automatic test_backpressure();
        clear_log();
        enable  = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(DW'(8'h10 + i));
        tick(10);
        checks++;
        if (rd_en_seen != 3 || outstanding != 3 || fifo_q.size() != 5) begin
            errors++;
            $display("FAIL bp_credit: reads=%0d held=%0d fifo_left=%0d, required 3 3 5",
                     rd_en_seen, outstanding, fifo_q.size());
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h10) begin
            errors++;
            $display("FAIL bp_head: valid=%b data=%h, required 1 10", m_valid, m_data);
        end
        m_ready = 1'b1;
        wait_drain(60, "bp");
        tick(2);
        check_log("bp", 8'h10, 8, 0);
    endtask

    task automatic test_empty_gap();
        clear_log();
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 1; i <= 5; i++) push_word(DW'(i));
        wait_drain(40, "gap_a");
        tick(5);
        for (int i = 6; i <= 8; i++) push_word(DW'(i));
        wait_drain(40, "gap_b");
        tick(2);
        check_log("gap", 8'h01, 8, 0);
    endtask

    task automatic test_enable_stop();
        int k = 0;
        int issued;
        clear_log();
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_word(DW'(8'h30 + i));
        while (rd_en_seen < 2 && k < 20) begin
            tick(1);
            k++;
        end
        enable = 1'b0;
        issued = rd_en_seen;
        tick(8);
        checks++;
        if (issued != 2 || rd_en_seen != issued || log_data.size() != issued ||
            outstanding != 0 || fifo_q.size() != 8 - issued || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL enable_stop: issued=%0d reads=%0d delivered=%0d held=%0d fifo_left=%0d valid=%b",
                     issued, rd_en_seen, log_data.size(), outstanding, fifo_q.size(), m_valid);
        end
        enable = 1'b1;
        wait_drain(40, "enable");
        tick(2);
        check_log("enable", 8'h30, 8, 0);
    endtask

    task automatic test_reset_mid_burst();
        int k = 0;
        clear_log();
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_word(DW'(8'h50 + i));
        while (log_data.size() < 2 && k < 20) begin
            tick(1);
            k++;
        end
        m_ready = 1'b0;
        tick(2);
        checks++;
        if (log_data.size() != 2 || outstanding < 2) begin
            errors++;
            $display("FAIL midrst_setup: accepted=%0d held=%0d, required 2 and >=2", log_data.size(), outstanding);
        end
        rst = 1'b1;
        tick(1);
        checks++;
        if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0 || beat_cnt !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: rd_en=%b valid=%b data=%h last=%b cnt=%0d, required all zero",
                     fifo_rd_en, m_valid, m_data, m_last, beat_cnt);
        end
        release_reset();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_discard: valid=%b data=%h after reset, required valid 0", m_valid, m_data);
        end
        clear_log();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_word(DW'(8'hA0 + i));
        wait_drain(40, "midrst");
        tick(2);
        check_log("midrst", 8'hA0, 8, 0);
        checks++;
        if (beat_cnt !== CW'(8)) begin
            errors++;
            $display("FAIL midrst_beat_cnt: got %0d expected 8", beat_cnt);
        end
    endtask

    task automatic test_random();
        clear_log();
        for (int c = 0; c < 800; c++) begin
            m_ready = ($urandom_range(0, 9) < 7);
            enable  = ($urandom_range(0, 9) < 8);
            if (fifo_q.size() < 12) begin
                int n = $urandom_range(0, 2);
                for (int j = 0; j < n; j++) push_word(DW'($urandom));
            end
            tick(1);
        end
        enable  = 1'b1;
        m_ready = 1'b1;
        wait_drain(200, "random");
        tick(2);
        checks++;
        if (log_data.size() != pushed || fifo_q.size() != 0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_totals: delivered=%0d written=%0d fifo_left=%0d valid=%b",
                     log_data.size(), pushed, fifo_q.size(), m_valid);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_empty_gap();
        test_enable_stop();
        test_reset_mid_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
